// File: rtl/dmi_req_queue.sv
// ----------------------------------------------------------------------------
// dmi_req_queue
//
// Request queue between a JTAG DMI scan register and the debug module. Each
// update-DR with a read/write op pushes {addr, data, op} into a small FIFO.
// The FIFO head is issued on a valid/ready request channel, one request in
// flight at a time. The response is absorbed into the read-data register
// that later capture-DR cycles shift out. Overflow and capture while busy
// raise a sticky "busy" error. The error is cleared only by dmi_reset_i or
// by reset.
//
// Optional feature (compile-time macro):
//   DMI_RESP_ERR_EN - when defined, a response with resp_resp_i == 2 or 3
//                     raises a sticky error of the same code. When undefined,
//                     resp_resp_i is ignored. The port stays present.
//
// Ports:
//   clk_i, rst_ni      clock, synchronous active-low reset
//   upd_valid_i        one-cycle update-DR strobe
//   upd_addr_i/data_i/op_i   scanned request (op 0 nop, 1 read, 2 write, 3 rsvd)
//   capture_i          one-cycle capture-DR strobe
//   dmi_reset_i        clears the sticky error (wins over same-cycle errors)
//   cap_addr_o/data_o/status_o  word loaded into the scan register at capture
//   req_valid_o/ready_i/addr_o/data_o/op_o  request channel to the DM
//   resp_valid_i/data_i/resp_i/ready_o      response channel from the DM
//   error_o            sticky error (0 none, 2 op failed, 3 busy)
//   pending_o          number of queued (not yet issued) requests
// ----------------------------------------------------------------------------
module dmi_req_queue #(
    parameter int AddrWidth = 7,
    parameter int DataWidth = 32,
    parameter int Depth     = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         upd_valid_i,
    input  logic [AddrWidth-1:0]         upd_addr_i,
    input  logic [DataWidth-1:0]         upd_data_i,
    input  logic [1:0]                   upd_op_i,
    input  logic                         capture_i,
    input  logic                         dmi_reset_i,
    output logic [AddrWidth-1:0]         cap_addr_o,
    output logic [DataWidth-1:0]         cap_data_o,
    output logic [1:0]                   cap_status_o,
    output logic                         req_valid_o,
    input  logic                         req_ready_i,
    output logic [AddrWidth-1:0]         req_addr_o,
    output logic [DataWidth-1:0]         req_data_o,
    output logic [1:0]                   req_op_o,
    input  logic                         resp_valid_i,
    input  logic [DataWidth-1:0]         resp_data_i,
    input  logic [1:0]                   resp_resp_i,
    output logic                         resp_ready_o,
    output logic [1:0]                   error_o,
    output logic [$clog2(Depth+1)-1:0]   pending_o
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);

    localparam logic [1:0] OpRead    = 2'd1;
    localparam logic [1:0] OpWrite   = 2'd2;
    localparam logic [1:0] ErrNone   = 2'd0;
    localparam logic [1:0] ErrFailed = 2'd2;
    localparam logic [1:0] ErrBusy   = 2'd3;

    typedef struct packed {
        logic [AddrWidth-1:0] addr;
        logic [DataWidth-1:0] data;
        logic [1:0]           op;
    } req_t;

    // Pointer advance that wraps at Depth, so non-power-of-two depths work.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    req_t                 mem_q [Depth];
    logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]      count_q, count_d;
    logic                 outstanding_q, outstanding_d;
    logic                 out_read_q, out_read_d;
    logic [AddrWidth-1:0] last_addr_q, last_addr_d;
    logic [DataWidth-1:0] rdata_q, rdata_d;
    logic [1:0]           error_q, error_d;

    req_t       head;
    logic       deq, enq, upd_cand, upd_busy, cap_busy, resp_acc, no_room;
    logic [1:0] resp_err, err_evt;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        head          = mem_q[rd_ptr_q];
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        out_read_d    = out_read_q;
        last_addr_d   = last_addr_q;
        rdata_d       = rdata_q;
        resp_err      = ErrNone;
        err_evt       = ErrNone;

        req_valid_o = (count_q != '0) && !outstanding_q;
        deq         = req_valid_o && req_ready_i;

        // A single-entry queue refuses new work while anything is in flight.
        // Deeper queues count a same-cycle dequeue as freeing a slot.
        if (Depth == 1) begin
            no_room = (count_q != '0) || outstanding_q;
        end else begin
            no_room = (count_q == CntW'(Depth)) && !deq;
        end

        // Only real ops take part. nop/reserved are dropped silently, and
        // nothing is accepted while an error is pending.
        upd_cand = upd_valid_i && (error_q == ErrNone) &&
                   ((upd_op_i == OpRead) || (upd_op_i == OpWrite));
        enq      = upd_cand && !no_room;
        upd_busy = upd_cand && no_room;

        cap_busy = capture_i && ((count_q != '0) || outstanding_q);
        resp_acc = resp_valid_i && outstanding_q;

`ifdef DMI_RESP_ERR_EN
        if (resp_acc && (resp_resp_i == ErrFailed || resp_resp_i == ErrBusy)) begin
            resp_err = resp_resp_i;
        end
`endif

        if (deq) begin
            rd_ptr_d      = ptr_inc(rd_ptr_q);
            outstanding_d = 1'b1;
            out_read_d    = (head.op == OpRead);
            last_addr_d   = head.addr;
        end

        // deq needs !outstanding_q and resp_acc needs outstanding_q, so the
        // two never collide.
        if (resp_acc) begin
            outstanding_d = 1'b0;
            if (out_read_q) begin
                rdata_d = resp_data_i;
            end
        end

        if (enq) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end

        case ({enq, deq})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        // The error is sticky and the first one wins. If two events land in
        // the same cycle, busy takes precedence over op-failed. dmi_reset_i
        // overrides everything.
        if (resp_err != ErrNone) begin
            err_evt = resp_err;
        end
        if (upd_busy || cap_busy) begin
            err_evt = ErrBusy;
        end
        error_d = (error_q == ErrNone) ? err_evt : error_q;
        if (dmi_reset_i) begin
            error_d = ErrNone;
        end
    end

    // Without the response-error feature the code is intentionally unused.
    logic unused_resp;
    assign unused_resp = ^resp_resp_i;

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    // NOTE: state is updated with non-blocking assignments. All registers then
    // sample the same pre-edge values, whatever order the statements are in.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            outstanding_q <= 1'b0;
            out_read_q    <= 1'b0;
            last_addr_q   <= '0;
            rdata_q       <= '0;
            error_q       <= ErrNone;
        end else begin
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            out_read_q    <= out_read_d;
            last_addr_q   <= last_addr_d;
            rdata_q       <= rdata_d;
            error_q       <= error_d;
        end
    end

    // NOTE: queue storage is deliberately not reset. count_q == 0 marks every
    // entry invalid, and a reset-free array maps onto plain RAM/flops.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_q[wr_ptr_q] <= '{addr: upd_addr_i, data: upd_data_i, op: upd_op_i};
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign req_addr_o   = head.addr;
    assign req_data_o   = head.data;
    assign req_op_o     = head.op;
    assign resp_ready_o = 1'b1;
    assign cap_addr_o   = last_addr_q;
    assign cap_data_o   = rdata_q;
    assign cap_status_o = cap_busy ? ErrBusy : error_q;
    assign error_o      = error_q;
    assign pending_o    = count_q;

endmodule

// File: tb/tb_dmi_req_queue.sv
module tb_dmi_req_queue;

    localparam int AW    = 7;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int PW    = $clog2(DEPTH + 1);

`ifdef DMI_RESP_ERR_EN
    localparam logic [1:0] EXP_FAIL_ERR = 2'd2;
    localparam bit         RESP_ERR_ON  = 1'b1;
`else
    localparam logic [1:0] EXP_FAIL_ERR = 2'd0;
    localparam bit         RESP_ERR_ON  = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          upd_valid_i;
    logic [AW-1:0] upd_addr_i;
    logic [DW-1:0] upd_data_i;
    logic [1:0]    upd_op_i;
    logic          capture_i;
    logic          dmi_reset_i;
    logic [AW-1:0] cap_addr_o;
    logic [DW-1:0] cap_data_o;
    logic [1:0]    cap_status_o;
    logic          req_valid_o;
    logic          req_ready_i;
    logic [AW-1:0] req_addr_o;
    logic [DW-1:0] req_data_o;
    logic [1:0]    req_op_o;
    logic          resp_valid_i;
    logic [DW-1:0] resp_data_i;
    logic [1:0]    resp_resp_i;
    logic          resp_ready_o;
    logic [1:0]    error_o;
    logic [PW-1:0] pending_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dmi_req_queue #(.AddrWidth(AW), .DataWidth(DW), .Depth(DEPTH)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .upd_valid_i(upd_valid_i), .upd_addr_i(upd_addr_i),
        .upd_data_i(upd_data_i), .upd_op_i(upd_op_i),
        .capture_i(capture_i), .dmi_reset_i(dmi_reset_i),
        .cap_addr_o(cap_addr_o), .cap_data_o(cap_data_o), .cap_status_o(cap_status_o),
        .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
        .req_addr_o(req_addr_o), .req_data_o(req_data_o), .req_op_o(req_op_o),
        .resp_valid_i(resp_valid_i), .resp_data_i(resp_data_i),
        .resp_resp_i(resp_resp_i), .resp_ready_o(resp_ready_o),
        .error_o(error_o), .pending_o(pending_o)
    );

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        upd_valid_i  = 1'b0; upd_addr_i  = '0; upd_data_i  = '0; upd_op_i = 2'd0;
        capture_i    = 1'b0; dmi_reset_i = 1'b0; req_ready_i = 1'b0;
        resp_valid_i = 1'b0; resp_data_i = '0; resp_resp_i = 2'd0;
    endtask

    task automatic push(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
        upd_valid_i = 1'b1; upd_op_i = op; upd_addr_i = a; upd_data_i = d;
        tick();
        upd_valid_i = 1'b0;
    endtask

    // Retire the in-flight request (if any) and every queued one with OK write-style responses.
    task automatic drain();
        resp_data_i = '0; resp_resp_i = 2'd0;
        repeat (DEPTH + 1) begin
            resp_valid_i = 1'b1; tick(); resp_valid_i = 1'b0;
            req_ready_i  = 1'b1; tick(); req_ready_i  = 1'b0;
        end
        resp_valid_i = 1'b1; tick(); resp_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst_ni = 1'b0;
        tick(); tick();
        n_cmp++; if (req_valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_req_valid: got %b want 0", req_valid_o); end
        n_cmp++; if (pending_o !== '0) begin n_bad++; $display("FAIL rst_pending: got %0d want 0", pending_o); end
        n_cmp++; if (error_o !== 2'd0) begin n_bad++; $display("FAIL rst_error: got %0d want 0", error_o); end
        n_cmp++; if (cap_addr_o !== '0) begin n_bad++; $display("FAIL rst_cap_addr: got %h want 0", cap_addr_o); end
        n_cmp++; if (cap_data_o !== '0) begin n_bad++; $display("FAIL rst_cap_data: got %h want 0", cap_data_o); end
        n_cmp++; if (cap_status_o !== 2'd0) begin n_bad++; $display("FAIL rst_cap_status: got %0d want 0", cap_status_o); end
        n_cmp++; if (resp_ready_o !== 1'b1) begin n_bad++; $display("FAIL rst_resp_ready: got %b want 1", resp_ready_o); end
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_read_basic();
        upd_valid_i = 1'b1; upd_op_i = 2'd1; upd_addr_i = 7'h10; upd_data_i = '0;
        #1;
        n_cmp++; if (req_valid_o !== 1'b0) begin n_bad++; $display("FAIL rd_valid_same_cycle: got %b want 0", req_valid_o); end
        tick();
        upd_valid_i = 1'b0;
        n_cmp++; if (req_valid_o !== 1'b1) begin n_bad++; $display("FAIL rd_valid_next: got %b want 1", req_valid_o); end
        n_cmp++; if (req_op_o !== 2'd1) begin n_bad++; $display("FAIL rd_op: got %0d want 1", req_op_o); end
        n_cmp++; if (req_addr_o !== 7'h10) begin n_bad++; $display("FAIL rd_addr: got %h want 10", req_addr_o); end
        n_cmp++; if (pending_o !== PW'(1)) begin n_bad++; $display("FAIL rd_pending: got %0d want 1", pending_o); end
        req_ready_i = 1'b1; tick(); req_ready_i = 1'b0;
        n_cmp++; if (req_valid_o !== 1'b0) begin n_bad++; $display("FAIL rd_outstanding_valid: got %b want 0", req_valid_o); end
        n_cmp++; if (cap_addr_o !== 7'h10) begin n_bad++; $display("FAIL rd_cap_addr: got %h want 10", cap_addr_o); end
        resp_valid_i = 1'b1; resp_data_i = 32'hDEADBEEF; resp_resp_i = 2'd0;
        tick();
        resp_valid_i = 1'b0;
        n_cmp++; if (cap_data_o !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd_cap_data: got %h want deadbeef", cap_data_o); end
        n_cmp++; if (error_o !== 2'd0) begin n_bad++; $display("FAIL rd_error: got %0d want 0", error_o); end
    endtask

    task automatic test_full_busy();
        req_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) push(2'd2, AW'(32 + i), DW'(i));
        n_cmp++; if (pending_o !== PW'(4)) begin n_bad++; $display("FAIL full_pending: got %0d want 4", pending_o); end
        n_cmp++; if (error_o !== 2'd3) begin n_bad++; $display("FAIL full_error: got %0d want 3", error_o); end
        push(2'd2, 7'h7F, 32'h1);
        n_cmp++; if (pending_o !== PW'(4)) begin n_bad++; $display("FAIL sixth_pending: got %0d want 4", pending_o); end
        n_cmp++; if (error_o !== 2'd3) begin n_bad++; $display("FAIL sixth_error: got %0d want 3", error_o); end
        dmi_reset_i = 1'b1; tick(); dmi_reset_i = 1'b0;
        n_cmp++; if (error_o !== 2'd0) begin n_bad++; $display("FAIL full_dmireset: got %0d want 0", error_o); end
        // Head order must be FIFO.
        for (int i = 0; i < DEPTH; i++) begin
            n_cmp++; if (req_addr_o !== AW'(32 + i) || req_op_o !== 2'd2 || req_valid_o !== 1'b1) begin
                n_bad++; $display("FAIL fifo_head%0d: got v=%b a=%h op=%0d want v=1 a=%h op=2", i, req_valid_o, req_addr_o, req_op_o, AW'(32 + i));
            end
            req_ready_i = 1'b1; tick(); req_ready_i = 1'b0;
            resp_valid_i = 1'b1; resp_data_i = 32'h5555AAAA; tick(); resp_valid_i = 1'b0;
        end
        n_cmp++; if (pending_o !== '0) begin n_bad++; $display("FAIL full_drained: got %0d want 0", pending_o); end
        n_cmp++; if (cap_data_o !== 32'hDEADBEEF) begin n_bad++; $display("FAIL write_keeps_rdata: got %h want deadbeef", cap_data_o); end
    endtask

    task automatic test_full_simul();
        for (int i = 0; i < 4; i++) push(2'd2, AW'(48 + i), DW'(i));
        n_cmp++; if (pending_o !== PW'(4) || error_o !== 2'd0) begin n_bad++; $display("FAIL simul_fill: got p=%0d e=%0d want p=4 e=0", pending_o, error_o); end
        req_ready_i = 1'b1;
        push(2'd2, 7'h34, 32'h34);
        req_ready_i = 1'b0;
        n_cmp++; if (pending_o !== PW'(4)) begin n_bad++; $display("FAIL simul_pending: got %0d want 4", pending_o); end
        n_cmp++; if (error_o !== 2'd0) begin n_bad++; $display("FAIL simul_error: got %0d want 0", error_o); end
        n_cmp++; if (cap_addr_o !== 7'h30) begin n_bad++; $display("FAIL simul_last_addr: got %h want 30", cap_addr_o); end
        drain();
        n_cmp++; if (pending_o !== '0 || req_valid_o !== 1'b0) begin n_bad++; $display("FAIL simul_drain: got p=%0d v=%b want p=0 v=0", pending_o, req_valid_o); end
    endtask

    task automatic test_capture_busy();
        push(2'd1, 7'h11, 32'h0);
        capture_i = 1'b1; req_ready_i = 1'b1;
        #1;
        n_cmp++; if (cap_status_o !== 2'd3) begin n_bad++; $display("FAIL cap_status_busy: got %0d want 3", cap_status_o); end
        tick();
        capture_i = 1'b0; req_ready_i = 1'b0;
        n_cmp++; if (error_o !== 2'd3) begin n_bad++; $display("FAIL cap_error: got %0d want 3", error_o); end
        n_cmp++; if (cap_status_o !== 2'd3) begin n_bad++; $display("FAIL cap_status_sticky: got %0d want 3", cap_status_o); end
        n_cmp++; if (req_valid_o !== 1'b0 || pending_o !== '0) begin n_bad++; $display("FAIL cap_outstanding: got v=%b p=%0d want v=0 p=0", req_valid_o, pending_o); end
        dmi_reset_i = 1'b1; capture_i = 1'b1;  // capture still busy, but the clear wins
        tick();
        dmi_reset_i = 1'b0; capture_i = 1'b0;
        n_cmp++; if (error_o !== 2'd0) begin n_bad++; $display("FAIL cap_dmireset: got %0d want 0", error_o); end
        resp_valid_i = 1'b1; resp_data_i = 32'h12345678; tick(); resp_valid_i = 1'b0;
        n_cmp++; if (cap_data_o !== 32'h12345678) begin n_bad++; $display("FAIL cap_rdata: got %h want 12345678", cap_data_o); end
    endtask

    task automatic test_resp_err();
        push(2'd2, 7'h05, 32'h0);
        req_ready_i = 1'b1; tick(); req_ready_i = 1'b0;
        resp_valid_i = 1'b1; resp_resp_i = 2'd2; resp_data_i = 32'hFFFF0000;
        tick();
        resp_valid_i = 1'b0; resp_resp_i = 2'd0;
        n_cmp++; if (error_o !== EXP_FAIL_ERR) begin n_bad++; $display("FAIL resp_err: got %0d want %0d", error_o, EXP_FAIL_ERR); end
        n_cmp++; if (cap_data_o !== 32'h12345678) begin n_bad++; $display("FAIL resp_err_rdata: got %h want 12345678", cap_data_o); end
        dmi_reset_i = 1'b1; tick(); dmi_reset_i = 1'b0;
    endtask

    task automatic test_reset_midflight();
        for (int i = 0; i < 3; i++) push(2'd1, AW'(64 + i), 32'h0);
        req_ready_i = 1'b1; tick(); req_ready_i = 1'b0;
        n_cmp++; if (pending_o !== PW'(2) || req_valid_o !== 1'b0) begin n_bad++; $display("FAIL mid_setup: got p=%0d v=%b want p=2 v=0", pending_o, req_valid_o); end
        rst_ni = 1'b0; tick(); rst_ni = 1'b1;
        n_cmp++; if (pending_o !== '0 || req_valid_o !== 1'b0) begin n_bad++; $display("FAIL mid_reset: got p=%0d v=%b want p=0 v=0", pending_o, req_valid_o); end
        n_cmp++; if (cap_data_o !== '0 || cap_addr_o !== '0) begin n_bad++; $display("FAIL mid_reset_cap: got a=%h d=%h want 0/0", cap_addr_o, cap_data_o); end
        resp_valid_i = 1'b1; resp_data_i = 32'hCAFEF00D; tick(); resp_valid_i = 1'b0;
        n_cmp++; if (cap_data_o !== '0) begin n_bad++; $display("FAIL stray_resp: got %h want 0", cap_data_o); end
        n_cmp++; if (req_valid_o !== 1'b0 || pending_o !== '0) begin n_bad++; $display("FAIL stray_resp_state: got v=%b p=%0d want 0/0", req_valid_o, pending_o); end
    endtask

    // Reference model: a queue of requests plus the in-flight/sticky state.
    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [1:0]    op;
    } ent_t;

    task automatic test_random();
        ent_t          mq[$];
        ent_t          e;
        bit            m_out, m_read;
        logic [AW-1:0] m_last;
        logic [DW-1:0] m_rdata;
        logic [1:0]    m_err, ev, exp_status;
        bit            exp_rv, deq, real_op, busy;

        idle();
        rst_ni = 1'b0; tick(); rst_ni = 1'b1;
        mq.delete(); m_out = 0; m_read = 0; m_last = '0; m_rdata = '0; m_err = 2'd0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst_ni       = ($urandom_range(0, 499) != 0);
            upd_valid_i  = ($urandom_range(0, 9) < 4);
            upd_op_i     = 2'($urandom_range(0, 3));
            upd_addr_i   = AW'($urandom);
            upd_data_i   = $urandom;
            req_ready_i  = $urandom_range(0, 1) == 1;
            resp_valid_i = ($urandom_range(0, 9) < 4);
            resp_data_i  = $urandom;
            resp_resp_i  = 2'($urandom_range(0, 3));
            capture_i    = ($urandom_range(0, 19) == 0);
            dmi_reset_i  = ($urandom_range(0, 9) == 0);
            #1;

            exp_rv     = (mq.size() != 0) && !m_out;
            exp_status = (capture_i && (mq.size() != 0 || m_out)) ? 2'd3 : m_err;
            n_cmp++; if (req_valid_o !== exp_rv) begin n_bad++; $display("FAIL rnd_req_valid c%0d: got %b want %b", cyc, req_valid_o, exp_rv); end
            n_cmp++; if (pending_o !== PW'(mq.size())) begin n_bad++; $display("FAIL rnd_pending c%0d: got %0d want %0d", cyc, pending_o, mq.size()); end
            n_cmp++; if (error_o !== m_err) begin n_bad++; $display("FAIL rnd_error c%0d: got %0d want %0d", cyc, error_o, m_err); end
            n_cmp++; if (cap_status_o !== exp_status) begin n_bad++; $display("FAIL rnd_cap_status c%0d: got %0d want %0d", cyc, cap_status_o, exp_status); end
            n_cmp++; if (cap_addr_o !== m_last || cap_data_o !== m_rdata) begin
                n_bad++; $display("FAIL rnd_cap_word c%0d: got %h/%h want %h/%h", cyc, cap_addr_o, cap_data_o, m_last, m_rdata);
            end
            if (exp_rv) begin
                n_cmp++; if (req_addr_o !== mq[0].addr || req_data_o !== mq[0].data || req_op_o !== mq[0].op) begin
                    n_bad++; $display("FAIL rnd_head c%0d: got %h/%h/%0d want %h/%h/%0d", cyc, req_addr_o, req_data_o, req_op_o, mq[0].addr, mq[0].data, mq[0].op);
                end
            end

            if (!rst_ni) begin
                mq.delete(); m_out = 0; m_read = 0; m_last = '0; m_rdata = '0; m_err = 2'd0;
            end else begin
                deq     = exp_rv && req_ready_i;
                real_op = upd_valid_i && (m_err == 2'd0) && (upd_op_i == 2'd1 || upd_op_i == 2'd2);
                busy    = (DEPTH == 1) ? (mq.size() != 0 || m_out) : (mq.size() == DEPTH && !deq);
                ev = 2'd0;
                if (RESP_ERR_ON && resp_valid_i && m_out && resp_resp_i >= 2'd2) ev = resp_resp_i;
                if ((real_op && busy) || (capture_i && (mq.size() != 0 || m_out))) ev = 2'd3;
                if (m_err == 2'd0) m_err = ev;
                if (dmi_reset_i) m_err = 2'd0;
                if (resp_valid_i && m_out) begin
                    m_out = 0;
                    if (m_read) m_rdata = resp_data_i;
                end else if (deq) begin
                    e = mq.pop_front();
                    m_out = 1; m_read = (e.op == 2'd1); m_last = e.addr;
                end
                if (real_op && !busy) mq.push_back('{addr: upd_addr_i, data: upd_data_i, op: upd_op_i});
            end
            tick();
        end
        idle();
        rst_ni = 1'b1;
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_full_busy();
        test_full_simul();
        test_capture_busy();
        test_resp_err();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
